// File: rtl/regfile_bank_if.sv
// -----------------------------------------------------------------------------
// regfile_bank_if
// Write / clear handshake bundle of the register-file storage stage.
//   wr_valid, wr_addr, wr_data : write request (master -> slave)
//   wr_ready                   : write can be accepted this cycle (slave -> master)
//   clr_req                    : bulk-clear request (master -> slave)
//   busy, clr_done, addr_err   : sequencer status and sticky bad-index flag
// -----------------------------------------------------------------------------
interface regfile_bank_if #(
   parameter int unsigned WIDTH = 16
);
   logic             wr_valid;
   logic             wr_ready;
   logic [3:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             clr_req;
   logic             busy;
   logic             clr_done;
   logic             addr_err;

   modport master (
      output wr_valid, wr_addr, wr_data, clr_req,
      input  wr_ready, busy, clr_done, addr_err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, clr_req,
      output wr_ready, busy, clr_done, addr_err
   );
endinterface

// File: rtl/regfile_bank.sv
// -----------------------------------------------------------------------------
// regfile_bank
// Storage for ten WIDTH-bit registers r0..r9 feeding the read-mux inputs a..j
// (a = r0, j = r9). Writes enter through a one-deep pending stage and commit one
// edge after acceptance. A sequencer zeroes r1..r9 on a clear request and pulses
// clr_done when finished. r0 is hardwired zero.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : regfile_bank_if slave (write handshake, clear request, status)
//   a..j   : contents of r0..r9
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a pending write is forwarded to its output
//                       one cycle before it commits.
// -----------------------------------------------------------------------------
module regfile_bank #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   regfile_bank_if.slave    bus,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] j
);

   typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       clr_idx_q, clr_idx_d;
   logic             pend_v_q;
   logic [3:0]       pend_addr_q;
   logic [WIDTH-1:0] pend_data_q;
   logic             addr_err_q;
   logic             busy_q;
   logic             clr_done_q;
   logic             accept;

   // r0 is never stored; it reads as constant zero
   logic [WIDTH-1:0] r_q  [1:NREGS-1];
   logic [WIDTH-1:0] view [NREGS];

   assign bus.wr_ready = (state_q == StIdle) & ~bus.clr_req;
   assign accept       = bus.wr_valid & bus.wr_ready;

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      unique case (state_q)
         StIdle: begin
            if (bus.clr_req) begin
               state_d   = StClear;
               clr_idx_d = 4'd1;
            end
         end
         StClear: begin
            clr_idx_d = clr_idx_q + 4'd1;
            if (clr_idx_q == 4'(NREGS - 1)) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         busy_q     <= (state_d != StIdle);
         clr_done_q <= (state_d == StDone);
      end
   end

   // ------------------------------------------------------------ pending stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         pend_v_q <= accept;
         if (accept) begin
            pend_addr_q <= bus.wr_addr;
            pend_data_q <= bus.wr_data;
            if (bus.wr_addr >= 4'(NREGS)) addr_err_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   // A commit and a clear zero never target the same edge: writes are only
   // accepted in StIdle, so the last commit lands on the StIdle->StClear edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < NREGS; k++) r_q[k] <= '0;
      end else begin
         for (int k = 1; k < NREGS; k++) begin
            if (pend_v_q && (pend_addr_q == 4'(k))) r_q[k] <= pend_data_q;
            if ((state_q == StClear) && (clr_idx_q == 4'(k))) r_q[k] <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- read view
   always_comb begin
      view[0] = '0;
      for (int k = 1; k < NREGS; k++) begin
         view[k] = r_q[k];
`ifdef REGFILE_BYPASS_EN
         if (pend_v_q && (pend_addr_q == 4'(k))) view[k] = pend_data_q;
`endif
      end
   end

   assign a = view[0];
   assign b = view[1];
   assign c = view[2];
   assign d = view[3];
   assign e = view[4];
   assign f = view[5];
   assign g = view[6];
   assign h = view[7];
   assign i = view[8];
   assign j = view[9];

   assign bus.busy     = busy_q;
   assign bus.clr_done = clr_done_q;
   assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_regfile_bank.sv
// -----------------------------------------------------------------------------
// tb_regfile_bank
// Directed and random stimulus against a reference model that tracks register
// contents, the pending write and the number of edges since a clear request.
// -----------------------------------------------------------------------------
module tb_regfile_bank;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_bank_if #(.WIDTH(16)) bus ();

   logic [15:0] a, b, c, d, e, f, g, h, i, j;

   regfile_bank #(.WIDTH(16), .NREGS(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .h     (h),
      .i     (i),
      .j     (j)
   );

`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   // reference model
   logic [15:0] m_r [10];
   bit          m_pv;
   int          m_pa;
   logic [15:0] m_pd;
   int          m_cyc;   // 0 = idle, else edges elapsed since the clear request
   bit          m_err;

   int n_vec  = 0;
   int n_err  = 0;
   int n_busy = 0;
   int n_done = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 10; k++) m_r[k] = '0;
      m_pv  = 1'b0;
      m_pa  = 0;
      m_pd  = '0;
      m_cyc = 0;
      m_err = 1'b0;
   endtask

   function automatic logic [15:0] exp_out(input int k);
      if (k == 0) return 16'h0;
      if (Bypass && m_pv && m_pa == k) return m_pd;
      return m_r[k];
   endfunction

   task automatic check_all();
      logic [15:0] obs [10];
      obs = '{a, b, c, d, e, f, g, h, i, j};
      for (int k = 0; k < 10; k++) chk($sformatf("out_r%0d", k), obs[k], exp_out(k));
      chk("busy", {15'b0, bus.busy}, {15'b0, m_cyc != 0});
      chk("clr_done", {15'b0, bus.clr_done}, {15'b0, m_cyc == 10});
      chk("addr_err", {15'b0, bus.addr_err}, {15'b0, m_err});
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic cycle(input bit v, input int ad, input logic [15:0] dat, input bit cr);
      bit rdy;
      bus.wr_valid = v;
      bus.wr_addr  = 4'(ad);
      bus.wr_data  = dat;
      bus.clr_req  = cr;
      #1;
      rdy = (m_cyc == 0) && !cr;
      chk("wr_ready", {15'b0, bus.wr_ready}, {15'b0, rdy});
      @(posedge clk);
      if (m_pv && m_pa >= 1 && m_pa <= 9) m_r[m_pa] = m_pd;
      if (m_cyc == 0) begin
         if (cr) m_cyc = 1;
      end else begin
         if (m_cyc <= 9) m_r[m_cyc] = '0;
         m_cyc = (m_cyc == 10) ? 0 : m_cyc + 1;
      end
      m_pv = v && rdy;
      m_pa = ad;
      m_pd = dat;
      if (v && rdy && ad >= 10) m_err = 1'b1;
      #1;
      check_all();
      if (bus.busy) n_busy++;
      if (bus.clr_done) n_done++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 0, 16'h0, 1'b0);
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.clr_req  = 1'b0;
      model_reset();

      // reset state
      #3;
      check_all();
      chk("reset_wr_ready", {15'b0, bus.wr_ready}, 16'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // single write, latency depends on bypass
      cycle(1'b1, 3, 16'h1234, 1'b0);
      chk("wr3_first_cycle", d, Bypass ? 16'h1234 : 16'h0000);
      idle(1);
      chk("wr3_committed", d, 16'h1234);

      // r0 write discarded, bad index flags sticky error
      cycle(1'b1, 0, 16'hFFFF, 1'b0);
      cycle(1'b1, 12, 16'hAAAA, 1'b0);
      chk("addr_err_rise", {15'b0, bus.addr_err}, 16'd1);
      idle(20);
      chk("addr_err_sticky", {15'b0, bus.addr_err}, 16'd1);
      chk("a_zero", a, 16'h0);
      chk("d_unchanged", d, 16'h1234);

      // back-to-back writes to r9
      cycle(1'b1, 9, 16'h0001, 1'b0);
      cycle(1'b1, 9, 16'h0002, 1'b0);
      cycle(1'b1, 9, 16'h0003, 1'b0);
      idle(1);
      chk("j_last_wins", j, 16'h0003);

      // load r1..r9, clear with wr_valid held high
      for (int k = 1; k <= 9; k++) cycle(1'b1, k, 16'(k * 16'h0101), 1'b0);
      idle(1);
      n_busy = 0;
      n_done = 0;
      cycle(1'b1, 4, 16'hBEEF, 1'b1);
      for (int k = 0; k < 9; k++) cycle(1'b1, 4, 16'hBEEF, 1'b0);
      chk("clr_r9_zero", j, 16'h0);
      chk("clr_r4_zero", e, 16'h0);
      cycle(1'b1, 4, 16'hBEEF, 1'b0);
      cycle(1'b0, 0, 16'h0, 1'b0);
      chk("clr_busy_cycles", 16'(n_busy), 16'd10);
      chk("clr_done_pulses", 16'(n_done), 16'd1);
      idle(1);

      // pending write commits on the clear-request edge
      cycle(1'b1, 5, 16'h5555, 1'b0);
      cycle(1'b0, 0, 16'h0, 1'b1);
      chk("f_commit_at_clr", f, 16'h5555);
      idle(4);
      chk("f_before_zero", f, 16'h5555);
      idle(1);
      chk("f_zeroed_k5", f, 16'h0);
      idle(6);

      // reset during clear
      for (int k = 1; k <= 9; k++) cycle(1'b1, k, 16'hC000 + 16'(k), 1'b0);
      idle(1);
      n_done = 0;
      cycle(1'b0, 0, 16'h0, 1'b1);
      idle(4);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all();
         if (bus.clr_done) n_done++;
      end
      rst_n = 1'b1;
      idle(12);
      chk("no_done_after_reset", 16'(n_done), 16'd0);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               16'($urandom), ($urandom_range(0, 24) == 0));
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
